gray_seq_ctrl: RTL and testbench
================================

Name: gray_seq_ctrl

Overview:
- Sequencer that drives a binary-to-Gray datapath: steps a WIDTH-bit binary index up or down and presents each index plus its Gray encoding as a valid/ready stream.
- Used to generate Gray-coded pointer and address sequences for downstream blocks such as FIFO pointers, encoder test patterns and scan addresses.
- Supports single-sweep and continuous (wrapping) modes, preload, and stop.

Parameters:
- WIDTH, 3, bit width of the binary index and the Gray output (must be >= 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  begin sequencing; honoured only in IDLE
- stop  input  1  abort sequencing; honoured in RUN (and blocks start in IDLE)
- dir  input  1  0 = count up, 1 = count down; latched at start
- mode  input  1  0 = single sweep, 1 = continuous; latched at start
- load  input  1  load load_val into the index; honoured only in IDLE
- load_val  input  WIDTH  preload value for the index
- out_ready  input  1  consumer accepts the current beat
- out_valid  output  1  bin_out/gray_out hold a valid beat
- bin_out  output  WIDTH  current binary index (registered)
- gray_out  output  WIDTH  bin_out ^ (bin_out >> 1), combinational from the index register
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at the end of a single sweep
- wrap  output  1  one-cycle pulse when the terminal beat is accepted

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge):
  - state <= IDLE; index <= 0, so bin_out = 0 and gray_out = 0.
  - out_valid = busy = done = wrap = 0; latched dir and mode <= 0.
  - Reset applies mid-RUN immediately. Any pending beat is dropped; no done or wrap pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - out_valid = 0.
  - load=1: index <= load_val.
  - start=1 and stop=0: latch dir and mode; go to RUN.
  - load and start in the same cycle: both take effect, and the first beat is load_val.
  - start and stop in the same cycle: stop wins; stay in IDLE (load still applies).
- RUN:
  - out_valid = 1 and busy = 1.
  - First beat appears the cycle after start (latency 1).
  - Accept = out_valid & out_ready. Without accept, index, bin_out and gray_out are held stable and no pulses are generated.
  - On accept: index <= index + 1 (dir=0) or index - 1 (dir=1), modulo 2^WIDTH.
  - Terminal value is 2^WIDTH-1 for up and 0 for down.
  - Accept of the terminal value:
    - wrap=1 next cycle for one cycle; index wraps (to 0 going up, to 2^WIDTH-1 going down).
    - mode=0: go to DONE.
    - mode=1: stay in RUN.
  - stop=1: go to IDLE next cycle; out_valid=0 from then on.
    - If the beat is also accepted that cycle, the index still advances and wrap still fires if terminal.
    - No done pulse.
  - stop beats terminal accept in single-sweep mode: go to IDLE and suppress done.
  - start, load, dir and mode changes are ignored while in RUN.
- DONE:
  - Lasts one cycle: done=1, out_valid=0, busy=0, then IDLE.
  - Index holds its post-wrap value.
  - Inputs are ignored in DONE.
- Sweep coverage: a single sweep from start value S emits every value from S to the terminal, inclusive.
  - Up sweep from 0 at WIDTH=3: 8 beats.
  - Preload 5, up: 3 beats.
- Gray encoding: gray_out[WIDTH-1] = bin_out[WIDTH-1]; gray_out[i] = bin_out[i+1] ^ bin_out[i]. Successive accepted beats differ in exactly one gray_out bit, including across a wrap.

Test Plan:
- Reset, then start with dir=0, mode=0, out_ready=1:
  - bin_out sequence is 0..7 and gray_out sequence is 000,001,011,010,110,111,101,100.
  - wrap pulses after the beat with value 7; done pulses the next cycle; index returns to 0.
- load_val=5 with load and start in the same cycle, dir=1, mode=0: beats 5,4,3,2,1,0 (gray 111,110,010,011,001,000); done pulses; index ends at 7.
- mode=1, dir=0, out_ready=1 for 20 cycles: continuous 0..7,0..7,0..3; a wrap pulse after each 7; done never asserts.
- Backpressure: out_ready=0 for 3 cycles while beat 2 is presented: bin_out=2 and gray_out=011 are held stable with out_valid=1; the sequence resumes at 3 once out_ready=1.
- stop asserted with an accepted beat of 4 in continuous mode: the following cycle is IDLE with out_valid=0, busy=0, bin_out=5, and no done.
- rst_n=0 mid-RUN at index 6: the next cycle shows all outputs 0 and IDLE; start with stop=1 in the same cycle stays in IDLE.

Source files
------------

// File: rtl/gray_seq_if.sv
// gray_seq_if
//   Bundles the control inputs and the valid/ready output stream of the
//   Gray-code sequencer.
//   master : the controlling side (drives start/stop/dir/mode/load/load_val
//            and out_ready; observes the stream and status pulses).
//   slave  : the sequencer itself.
//   Signals:
//     start, stop, dir, mode, load, load_val  control towards the sequencer
//     out_ready                               consumer accepts current beat
//     out_valid, bin_out, gray_out            output stream
//     busy, done, wrap                        status / event pulses
interface gray_seq_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             stop;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, stop, dir, mode, load, load_val, out_ready,
    input  out_valid, bin_out, gray_out, busy, done, wrap
  );

  modport slave (
    input  start, stop, dir, mode, load, load_val, out_ready,
    output out_valid, bin_out, gray_out, busy, done, wrap
  );
endinterface

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
//   Steps a WIDTH-bit binary index up or down and presents each index plus
//   its Gray encoding as a valid/ready stream. Supports a single sweep to
//   the terminal value (DONE afterwards) or continuous wrapping, a preload
//   of the index while idle, and an abort via stop.
//   Ports:
//     clk    rising-edge system clock
//     rst_n  synchronous, active-low reset
//     bus    gray_seq_if slave modport (control inputs, output stream,
//            busy/done/wrap status)
//   bin_out, out_valid, busy, done and wrap are registered; gray_out is a
//   combinational function of the index register.
module gray_seq_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  gray_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] IDX_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] IDX_MAX = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  state_t           state;
  logic [WIDTH-1:0] idx;
  logic             dir_q;
  logic             mode_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             wrap_q;

  logic             accept;
  logic             terminal;
  logic [WIDTH-1:0] idx_step;

  assign accept   = valid_q & bus.out_ready;
  // Terminal is the last value of a sweep in the latched direction.
  assign terminal = dir_q ? (idx == '0) : (idx == IDX_MAX);
  // Modulo arithmetic gives the wrap (max->0 up, 0->max down) for free.
  assign idx_step = dir_q ? (idx - IDX_ONE) : (idx + IDX_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load)
            idx <= bus.load_val;
          // stop in the same cycle vetoes the start.
          if (bus.start && !bus.stop) begin
            dir_q   <= bus.dir;
            mode_q  <= bus.mode;
            state   <= RUN;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end

        RUN: begin
          if (accept) begin
            idx <= idx_step;
            if (terminal)
              wrap_q <= 1'b1;
          end
          // stop takes priority over the end-of-sweep transition and
          // suppresses done, but an accepted beat still advances.
          if (bus.stop) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (accept && terminal && !mode_q) begin
            state   <= DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.bin_out   = idx;
  assign bus.gray_out  = bin2gray(idx);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl
//   Directed-vector bench for gray_seq_ctrl at WIDTH=3. Each scenario task
//   drives stimulus and compares outputs against hand-computed values.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_gray_seq_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  gray_seq_if #(.WIDTH(3)) bus ();

  gray_seq_ctrl #(.WIDTH(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.start     = 1'b1;
    bus.stop      = 1'b0;
    bus.dir       = 1'b1;
    bus.mode      = 1'b1;
    bus.load      = 1'b1;
    bus.load_val  = 3'd6;
    bus.out_ready = 1'b1;
    step();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", bus.wrap); end
    total++; if (bus.bin_out !== 3'd0) begin bad++; $display("FAIL reset_bin got=%0d want=0", bus.bin_out); end
    total++; if (bus.gray_out !== 3'b000) begin bad++; $display("FAIL reset_gray got=%b want=000", bus.gray_out); end
    // start+stop+load together: load applies, start is vetoed.
    rst_n        = 1'b1;
    bus.start    = 1'b1;
    bus.stop     = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 3'd3;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.load  = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL startstop_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL startstop_busy got=%b want=0", bus.busy); end
    total++; if (bus.bin_out !== 3'd3) begin bad++; $display("FAIL startstop_load_bin got=%0d want=3", bus.bin_out); end
    total++; if (bus.gray_out !== 3'b010) begin bad++; $display("FAIL startstop_load_gray got=%b want=010", bus.gray_out); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL startstop_idle_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_up_sweep();
    logic [2:0] gray_exp [8];
    gray_exp = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    bus.load      = 1'b1;
    bus.load_val  = 3'd0;
    bus.start     = 1'b1;
    bus.dir       = 1'b0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    // These changes during RUN must be ignored.
    bus.load     = 1'b1;
    bus.load_val = 3'd6;
    bus.dir      = 1'b1;
    bus.mode     = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL up_valid k=%0d got=%b want=1", k, bus.out_valid); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL up_busy k=%0d got=%b want=1", k, bus.busy); end
      total++; if (bus.bin_out !== 3'(k)) begin bad++; $display("FAIL up_bin k=%0d got=%0d want=%0d", k, bus.bin_out, k); end
      total++; if (bus.gray_out !== gray_exp[k]) begin bad++; $display("FAIL up_gray k=%0d got=%b want=%b", k, bus.gray_out, gray_exp[k]); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL up_wrap_early k=%0d got=%b want=0", k, bus.wrap); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL up_done_early k=%0d got=%b want=0", k, bus.done); end
      step();
    end
    bus.load = 1'b0;
    bus.dir  = 1'b0;
    bus.mode = 1'b0;
    total++; if (bus.wrap !== 1'b1) begin bad++; $display("FAIL up_wrap got=%b want=1", bus.wrap); end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL up_done got=%b want=1", bus.done); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL up_end_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL up_end_busy got=%b want=0", bus.busy); end
    total++; if (bus.bin_out !== 3'd0) begin bad++; $display("FAIL up_end_bin got=%0d want=0", bus.bin_out); end
    step();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL up_done_pulse got=%b want=0", bus.done); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL up_wrap_pulse got=%b want=0", bus.wrap); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL up_idle_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_down_preload();
    logic [2:0] bin_exp  [6];
    logic [2:0] gray_exp [6];
    bin_exp  = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    gray_exp = '{3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};
    bus.load      = 1'b1;
    bus.load_val  = 3'd5;
    bus.start     = 1'b1;
    bus.dir       = 1'b1;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL down_valid k=%0d got=%b want=1", k, bus.out_valid); end
      total++; if (bus.bin_out !== bin_exp[k]) begin bad++; $display("FAIL down_bin k=%0d got=%0d want=%0d", k, bus.bin_out, bin_exp[k]); end
      total++; if (bus.gray_out !== gray_exp[k]) begin bad++; $display("FAIL down_gray k=%0d got=%b want=%b", k, bus.gray_out, gray_exp[k]); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL down_done_early k=%0d got=%b want=0", k, bus.done); end
      step();
    end
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL down_done got=%b want=1", bus.done); end
    total++; if (bus.wrap !== 1'b1) begin bad++; $display("FAIL down_wrap got=%b want=1", bus.wrap); end
    total++; if (bus.bin_out !== 3'd7) begin bad++; $display("FAIL down_end_bin got=%0d want=7", bus.bin_out); end
    total++; if (bus.gray_out !== 3'b100) begin bad++; $display("FAIL down_end_gray got=%b want=100", bus.gray_out); end
    step();
    bus.dir = 1'b0;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL down_done_pulse got=%b want=0", bus.done); end
    total++; if (bus.bin_out !== 3'd7) begin bad++; $display("FAIL down_hold_bin got=%0d want=7", bus.bin_out); end
  endtask

  task automatic test_continuous_stop();
    bus.load      = 1'b1;
    bus.load_val  = 3'd0;
    bus.start     = 1'b1;
    bus.dir       = 1'b0;
    bus.mode      = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL cont_valid k=%0d got=%b want=1", k, bus.out_valid); end
      total++; if (bus.bin_out !== 3'(k % 8)) begin bad++; $display("FAIL cont_bin k=%0d got=%0d want=%0d", k, bus.bin_out, k % 8); end
      total++; if (bus.wrap !== ((k > 0) && (k % 8 == 0))) begin bad++; $display("FAIL cont_wrap k=%0d got=%b want=%b", k, bus.wrap, ((k > 0) && (k % 8 == 0))); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL cont_done k=%0d got=%b want=0", k, bus.done); end
      step();
    end
    total++; if (bus.bin_out !== 3'd4) begin bad++; $display("FAIL cont_pre_stop_bin got=%0d want=4", bus.bin_out); end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stop_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b want=0", bus.busy); end
    total++; if (bus.bin_out !== 3'd5) begin bad++; $display("FAIL stop_bin got=%0d want=5", bus.bin_out); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL stop_done got=%b want=0", bus.done); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stop_idle_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL stop_idle_done got=%b want=0", bus.done); end
    bus.mode = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    bus.load      = 1'b1;
    bus.load_val  = 3'd0;
    bus.start     = 1'b1;
    bus.dir       = 1'b0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    step();
    step();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid k=%0d got=%b want=1", k, bus.out_valid); end
      total++; if (bus.bin_out !== 3'd2) begin bad++; $display("FAIL bp_bin k=%0d got=%0d want=2", k, bus.bin_out); end
      total++; if (bus.gray_out !== 3'b011) begin bad++; $display("FAIL bp_gray k=%0d got=%b want=011", k, bus.gray_out); end
      total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL bp_wrap k=%0d got=%b want=0", k, bus.wrap); end
      step();
    end
    bus.out_ready = 1'b1;
    for (int k = 2; k < 7; k++) begin
      total++; if (bus.bin_out !== 3'(k)) begin bad++; $display("FAIL bp_resume_bin got=%0d want=%0d", bus.bin_out, k); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_resume_valid k=%0d got=%b want=1", k, bus.out_valid); end
      if (k < 6) step();
    end
    // Reset lands while beat 6 is presented.
    rst_n = 1'b0;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", bus.done); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL midrst_wrap got=%b want=0", bus.wrap); end
    total++; if (bus.bin_out !== 3'd0) begin bad++; $display("FAIL midrst_bin got=%0d want=0", bus.bin_out); end
    total++; if (bus.gray_out !== 3'b000) begin bad++; $display("FAIL midrst_gray got=%b want=000", bus.gray_out); end
    rst_n     = 1'b1;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_startstop_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_startstop_busy got=%b want=0", bus.busy); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_idle_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.bin_out !== 3'd0) begin bad++; $display("FAIL rst_idle_bin got=%0d want=0", bus.bin_out); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_up_sweep();
    test_down_preload();
    test_continuous_stop();
    test_backpressure_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
